// File: rtl/life_event_scheduler_pkg.sv
// Shared types and widths for the life event scheduler and its testbench.
package life_pkg;

  localparam int LIFE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_DEAD
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_SET,
    CMD_ADD,
    CMD_REMOVE
  } cmd_e;

endpackage

// File: rtl/life_event_scheduler_if.sv
// Request/ack bus between game logic, the life tracker and the scheduler.
// currLife is driven by the tracker, which sits on the requester side.
interface life_event_scheduler_if;
  import life_pkg::*;

  logic              hitReq;
  logic [LIFE_W-1:0] hitAmount;
  logic              healReq;
  logic [LIFE_W-1:0] healAmount;
  logic              restartReq;
  logic [LIFE_W-1:0] currLife;

  logic [LIFE_W-1:0] amount;
  logic              enableSetLife;
  logic              enableAddLife;
  logic              enableRemoveLife;
  logic              hitAck;
  logic              healAck;
  logic              restartAck;
  logic              invulnerable;
  logic              gameOver;

  modport master (
    output hitReq, hitAmount, healReq, healAmount, restartReq, currLife,
    input  amount, enableSetLife, enableAddLife, enableRemoveLife,
           hitAck, healAck, restartAck, invulnerable, gameOver
  );

  modport slave (
    input  hitReq, hitAmount, healReq, healAmount, restartReq, currLife,
    output amount, enableSetLife, enableAddLife, enableRemoveLife,
           hitAck, healAck, restartAck, invulnerable, gameOver
  );

endinterface

// File: rtl/life_event_scheduler_invuln_timer.sv
// Post-hit immunity down-counter. clear wins over load; active while nonzero.
module invuln_timer #(
  parameter int INVULN_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic resetN,
  input  logic load,
  input  logic clear,
  output logic active
);

  localparam int CNT_W = $clog2(INVULN_CYCLES + 1);

  logic [CNT_W-1:0] r_count;

  // Count down once per cycle after a load; restart forces the window closed.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= CNT_W'(INVULN_CYCLES);
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign active = (r_count != '0);

endmodule

// File: rtl/life_event_scheduler.sv
// Arbitrates restart/hit/heal requests into single tracker commands,
// enforces the post-hit immunity window, clamps heals and flags game-over.
module life_event_scheduler
  import life_pkg::*;
#(
  parameter int START_LIFE    = 3,
  parameter int MAX_LIFE      = 7,
  parameter int INVULN_CYCLES = 25_000_000
) (
  input logic                   clk,
  input logic                   resetN,
  life_event_scheduler_if.slave bus
);

  state_e            r_state;
  cmd_e              r_cmd;
  logic [LIFE_W-1:0] r_amount;
  logic              r_setStb;
  logic              r_addStb;
  logic              r_remStb;
  logic              r_hitAck;
  logic              r_healAck;
  logic              r_restartAck;
  logic              r_gameOver;

  logic              w_invuln;
  logic              w_ackBusy;
  logic              w_svc;
  logic              w_doRestart;
  logic              w_doHit;
  logic              w_doHeal;
  logic              w_load;
  logic              w_clear;
  logic [LIFE_W-1:0] w_healAmt;

  // Largest heal that keeps life at or below MAX_LIFE; room saturates at 0.
  function automatic logic [LIFE_W-1:0] heal_clamp(
    input logic [LIFE_W-1:0] req,
    input logic [LIFE_W-1:0] curr
  );
    logic [LIFE_W:0] room;
    if ({1'b0, curr} >= (LIFE_W+1)'(MAX_LIFE)) begin
      room = '0;
    end else begin
      room = (LIFE_W+1)'(MAX_LIFE) - {1'b0, curr};
    end
    if ({1'b0, req} < room) begin
      heal_clamp = req;
    end else begin
      heal_clamp = room[LIFE_W-1:0];
    end
  endfunction

  // A request is only looked at in IDLE/DEAD, and never in the cycle its ack
  // is being shown, so a requester dropping on the ack edge is not re-served.
  always_comb begin
    w_ackBusy   = r_hitAck | r_healAck | r_restartAck;
    w_svc       = ((r_state == ST_IDLE) || (r_state == ST_DEAD)) && !w_ackBusy;
    w_doRestart = w_svc && bus.restartReq;
    w_doHit     = w_svc && !bus.restartReq && bus.hitReq;
    w_doHeal    = w_svc && !bus.restartReq && !bus.hitReq && bus.healReq;
    w_healAmt   = heal_clamp(bus.healAmount, bus.currLife);
    w_clear     = w_doRestart;
    w_load      = (r_state == ST_SETTLE) && (r_cmd == CMD_REMOVE) &&
                  (bus.currLife != '0);
  end

  invuln_timer #(
    .INVULN_CYCLES(INVULN_CYCLES)
  ) u_timer (
    .clk    (clk),
    .resetN (resetN),
    .load   (w_load),
    .clear  (w_clear),
    .active (w_invuln)
  );

  // Main FSM: strobes and acks are single-cycle registered pulses.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= ST_IDLE;
      r_cmd        <= CMD_NONE;
      r_amount     <= '0;
      r_setStb     <= 1'b0;
      r_addStb     <= 1'b0;
      r_remStb     <= 1'b0;
      r_hitAck     <= 1'b0;
      r_healAck    <= 1'b0;
      r_restartAck <= 1'b0;
      r_gameOver   <= 1'b0;
    end else begin
      r_setStb     <= 1'b0;
      r_addStb     <= 1'b0;
      r_remStb     <= 1'b0;
      r_hitAck     <= 1'b0;
      r_healAck    <= 1'b0;
      r_restartAck <= 1'b0;

      if (w_doRestart) begin
        r_restartAck <= 1'b1;
        r_setStb     <= 1'b1;
        r_amount     <= LIFE_W'(START_LIFE);
        r_cmd        <= CMD_SET;
        r_state      <= ST_ISSUE;
      end else if (w_doHit) begin
        r_hitAck <= 1'b1;
        if ((r_state == ST_IDLE) && !w_invuln) begin
          r_remStb <= 1'b1;
          r_amount <= bus.hitAmount;
          r_cmd    <= CMD_REMOVE;
          r_state  <= ST_ISSUE;
        end
      end else if (w_doHeal) begin
        r_healAck <= 1'b1;
        if ((r_state == ST_IDLE) && (w_healAmt != '0)) begin
          r_addStb <= 1'b1;
          r_amount <= w_healAmt;
          r_cmd    <= CMD_ADD;
          r_state  <= ST_ISSUE;
        end
      end

      case (r_state)
        ST_ISSUE: begin
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          r_cmd   <= CMD_NONE;
          r_state <= ST_IDLE;
          if ((r_cmd == CMD_REMOVE) && (bus.currLife == '0)) begin
            r_state    <= ST_DEAD;
            r_gameOver <= 1'b1;
          end
          if (r_cmd == CMD_SET) begin
            r_gameOver <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.amount           = r_amount;
  assign bus.enableSetLife    = r_setStb;
  assign bus.enableAddLife    = r_addStb;
  assign bus.enableRemoveLife = r_remStb;
  assign bus.hitAck           = r_hitAck;
  assign bus.healAck          = r_healAck;
  assign bus.restartAck       = r_restartAck;
  assign bus.invulnerable     = w_invuln;
  assign bus.gameOver         = r_gameOver;

endmodule

// File: tb/tb_life_event_scheduler.sv
// Directed bench for life_event_scheduler with a behavioural life tracker.
module tb_life_event_scheduler;
  import life_pkg::*;

  logic clk = 1'b0;
  logic resetN;
  logic trkRstN;
  logic [2:0] trkLife;
  int checks = 0;
  int errors = 0;

  int          lat;
  logic [2:0]  strb;
  logic [2:0]  amt;
  int          invCnt;

  life_event_scheduler_if bus();

  life_event_scheduler #(
    .START_LIFE    (3),
    .MAX_LIFE      (7),
    .INVULN_CYCLES (8)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Life tracker: set / saturating add / floored remove.
  always @(posedge clk) begin
    if (!trkRstN) trkLife <= 3'd3;
    else if (bus.enableSetLife) trkLife <= bus.amount;
    else if (bus.enableAddLife)
      trkLife <= ({1'b0, trkLife} + {1'b0, bus.amount} > 4'd7) ? 3'd7 : trkLife + bus.amount;
    else if (bus.enableRemoveLife)
      trkLife <= (trkLife > bus.amount) ? trkLife - bus.amount : 3'd0;
  end
  assign bus.currLife = trkLife;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // kind: 0 restart, 1 hit, 2 heal. Returns ack latency (-1 if none) and
  // the {set,add,remove} strobes and amount seen in the ack cycle.
  task automatic issue(input int kind, input logic [2:0] a, output int l,
                       output logic [2:0] s, output logic [2:0] ao);
    @(negedge clk);
    if (kind == 0) bus.restartReq = 1'b1;
    if (kind == 1) begin bus.hitReq = 1'b1; bus.hitAmount = a; end
    if (kind == 2) begin bus.healReq = 1'b1; bus.healAmount = a; end
    l = -1; s = 3'b000; ao = 3'b000;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if ((kind == 0 && bus.restartAck) || (kind == 1 && bus.hitAck) ||
          (kind == 2 && bus.healAck)) begin
        l  = i;
        s  = {bus.enableSetLife, bus.enableAddLife, bus.enableRemoveLife};
        ao = bus.amount;
        break;
      end
    end
    bus.restartReq = 1'b0;
    bus.hitReq     = 1'b0;
    bus.healReq    = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    resetN = 1'b0; trkRstN = 1'b0;
    bus.hitReq = 1'b0; bus.hitAmount = '0;
    bus.healReq = 1'b0; bus.healAmount = '0;
    bus.restartReq = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_amount", 32'(bus.amount), 0);
    chk("rst_strobes", 32'({bus.enableSetLife, bus.enableAddLife, bus.enableRemoveLife}), 0);
    chk("rst_acks", 32'({bus.hitAck, bus.healAck, bus.restartAck}), 0);
    chk("rst_invuln", 32'(bus.invulnerable), 0);
    chk("rst_gameover", 32'(bus.gameOver), 0);
    trkRstN = 1'b1; resetN = 1'b1;
    @(negedge clk);
    chk("start_life", 32'(trkLife), 3);

    // 1. hit of 1 from life 3, with 2. a second hit inside the window
    @(negedge clk); bus.hitReq = 1'b1; bus.hitAmount = 3'd1;
    @(negedge clk);
    chk("hit1_remove", 32'(bus.enableRemoveLife), 1);
    chk("hit1_amount", 32'(bus.amount), 1);
    chk("hit1_ack", 32'(bus.hitAck), 1);
    chk("hit1_other_stb", 32'({bus.enableSetLife, bus.enableAddLife}), 0);
    bus.hitReq = 1'b0;
    @(negedge clk);
    chk("hit1_life", 32'(trkLife), 2);
    chk("hit1_settle_inv", 32'(bus.invulnerable), 0);
    invCnt = 0;
    @(negedge clk); if (bus.invulnerable) invCnt++;
    @(negedge clk); if (bus.invulnerable) invCnt++;
    @(negedge clk); if (bus.invulnerable) invCnt++;
    bus.hitReq = 1'b1; bus.hitAmount = 3'd3;
    @(negedge clk); if (bus.invulnerable) invCnt++;
    chk("hit2_ack", 32'(bus.hitAck), 1);
    chk("hit2_no_remove", 32'(bus.enableRemoveLife), 0);
    bus.hitReq = 1'b0;
    @(negedge clk); if (bus.invulnerable) invCnt++;
    chk("hit2_life", 32'(trkLife), 2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.invulnerable) break;
      invCnt++;
    end
    chk("invuln_len", 32'(invCnt), 8);

    // 3. heal clamp
    issue(2, 3'd3, lat, strb, amt);
    chk("heal3_lat", 32'(lat), 1);
    chk("heal3_stb", 32'(strb), 3'b010);
    chk("heal3_amt", 32'(amt), 3);
    chk("heal3_life", 32'(trkLife), 5);
    issue(2, 3'd7, lat, strb, amt);
    chk("heal7_stb", 32'(strb), 3'b010);
    chk("heal7_amt", 32'(amt), 2);
    chk("heal7_life", 32'(trkLife), 7);
    issue(2, 3'd1, lat, strb, amt);
    chk("heal_full_lat", 32'(lat), 1);
    chk("heal_full_stb", 32'(strb), 0);
    chk("heal_full_life", 32'(trkLife), 7);

    // 4. fatal hit, drops in DEAD, restart
    issue(0, 3'd0, lat, strb, amt);
    chk("rs1_stb", 32'(strb), 3'b100);
    chk("rs1_amt", 32'(amt), 3);
    chk("rs1_life", 32'(trkLife), 3);
    issue(1, 3'd5, lat, strb, amt);
    chk("fatal_stb", 32'(strb), 3'b001);
    chk("fatal_amt", 32'(amt), 5);
    chk("fatal_life", 32'(trkLife), 0);
    chk("fatal_gameover", 32'(bus.gameOver), 1);
    chk("fatal_inv", 32'(bus.invulnerable), 0);
    issue(2, 3'd2, lat, strb, amt);
    chk("dead_heal_lat", 32'(lat), 1);
    chk("dead_heal_stb", 32'(strb), 0);
    chk("dead_heal_life", 32'(trkLife), 0);
    issue(1, 3'd1, lat, strb, amt);
    chk("dead_hit_lat", 32'(lat), 1);
    chk("dead_hit_stb", 32'(strb), 0);
    chk("dead_gameover", 32'(bus.gameOver), 1);
    issue(0, 3'd0, lat, strb, amt);
    chk("rs2_stb", 32'(strb), 3'b100);
    chk("rs2_amt", 32'(amt), 3);
    chk("rs2_gameover", 32'(bus.gameOver), 0);
    chk("rs2_inv", 32'(bus.invulnerable), 0);
    chk("rs2_life", 32'(trkLife), 3);

    // 5. simultaneous requests at life 1
    issue(1, 3'd2, lat, strb, amt);
    chk("pre5_life", 32'(trkLife), 1);
    @(negedge clk);
    bus.restartReq = 1'b1; bus.hitReq = 1'b1; bus.healReq = 1'b1;
    bus.hitAmount = 3'd1; bus.healAmount = 3'd2;
    @(negedge clk);
    chk("sim_c1_acks", 32'({bus.restartAck, bus.hitAck, bus.healAck}), 3'b100);
    chk("sim_c1_set", 32'(bus.enableSetLife), 1);
    chk("sim_c1_amt", 32'(bus.amount), 3);
    bus.restartReq = 1'b0;
    @(negedge clk);
    chk("sim_c2_life", 32'(trkLife), 3);
    @(negedge clk);
    chk("sim_c3_acks", 32'({bus.restartAck, bus.hitAck, bus.healAck}), 0);
    @(negedge clk);
    chk("sim_c4_acks", 32'({bus.restartAck, bus.hitAck, bus.healAck}), 3'b010);
    chk("sim_c4_remove", 32'(bus.enableRemoveLife), 1);
    chk("sim_c4_amt", 32'(bus.amount), 1);
    bus.hitReq = 1'b0;
    @(negedge clk);
    chk("sim_c5_life", 32'(trkLife), 2);
    @(negedge clk);
    chk("sim_c6_acks", 32'({bus.restartAck, bus.hitAck, bus.healAck}), 0);
    @(negedge clk);
    chk("sim_c7_acks", 32'({bus.restartAck, bus.hitAck, bus.healAck}), 3'b001);
    chk("sim_c7_add", 32'(bus.enableAddLife), 1);
    chk("sim_c7_amt", 32'(bus.amount), 2);
    chk("sim_c7_inv", 32'(bus.invulnerable), 1);
    bus.healReq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sim_c9_life", 32'(trkLife), 4);

    // 6. reset asserted while a heal command is in ISSUE
    bus.healReq = 1'b1; bus.healAmount = 3'd1;
    @(posedge clk); #1;
    chk("mid_add_before", 32'(bus.enableAddLife), 1);
    chk("mid_inv_before", 32'(bus.invulnerable), 1);
    resetN = 1'b0;
    #1;
    chk("mid_add_after", 32'(bus.enableAddLife), 0);
    chk("mid_ack_after", 32'(bus.healAck), 0);
    chk("mid_inv_after", 32'(bus.invulnerable), 0);
    bus.healReq = 1'b0;
    @(negedge clk); @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    chk("post_rst_outs", 32'({bus.enableSetLife, bus.enableAddLife, bus.enableRemoveLife,
                              bus.hitAck, bus.healAck, bus.restartAck, bus.gameOver}), 0);
    chk("post_rst_inv", 32'(bus.invulnerable), 0);
    chk("post_rst_life", 32'(trkLife), 4);
    issue(2, 3'd1, lat, strb, amt);
    chk("post_rst_heal_lat", 32'(lat), 1);
    chk("post_rst_heal_stb", 32'(strb), 3'b010);
    chk("post_rst_heal_life", 32'(trkLife), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_event_scheduler.md
# life_event_scheduler

Sequencer in front of the player life tracker (`lifeTracker`). It collects damage, heal and restart requests from game logic (collision detector, pickup logic, level FSM) over a request/ack handshake. It arbitrates among them and issues exactly one set/add/remove command at a time. It also enforces a post-hit invulnerability window, clamps healing to a maximum, and flags game-over.

## Interface
Parameters:
- START_LIFE, 3: value written on restart.
- MAX_LIFE, 7: heal ceiling; must be ≤ 7.
- INVULN_CYCLES, 25_000_000: length of the post-hit immunity window, in clk cycles; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset; asynchronous, active-low.
- hitReq  in  1  damage request; level, held until hitAck.
- hitAmount  in  3  damage value; stable while hitReq is high.
- healReq  in  1  heal request; level, held until healAck.
- healAmount  in  3  heal value; stable while healReq is high.
- restartReq  in  1  restore-life request; level, held until restartAck.
- currLife  in  3  current life, taken from the tracker output.
- amount  out  3  command operand to the tracker.
- enableSetLife / enableAddLife / enableRemoveLife  out  1 each  one-hot command strobes.
- hitAck / healAck / restartAck  out  1 each  one-cycle acceptance pulses.
- invulnerable  out  1  immunity window active.
- gameOver  out  1  life reached 0; only a restart clears it.

## Operation
- FSM states: IDLE, ISSUE, SETTLE, DEAD.
- IDLE: evaluate requests with fixed priority restart > hit > heal.
  - An unserved request is not acked and stays pending.
- Restart, from IDLE or DEAD:
  - Issue a set command with amount = START_LIFE.
  - Clear the invulnerability counter.
- Hit, in IDLE with invulnerable = 0: issue a remove command with amount = hitAmount. The tracker floors the result at 0.
- Hit, in IDLE with invulnerable = 1: pulse hitAck, issue no command, stay in IDLE. The hit is discarded.
- Heal: compute room = MAX_LIFE − currLife in 4-bit arithmetic, saturating at 0.
  - Issue an add command with amount = min(healAmount, room).
  - If that amount is 0, pulse healAck only, with no strobe.
- ISSUE: exactly one strobe and the matching ack are high for this single cycle; go to SETTLE.
- SETTLE: currLife now reflects the command.
  - After a hit command with currLife == 0: go to DEAD.
  - After a hit command with currLife ≠ 0: load the counter with INVULN_CYCLES, then go to IDLE.
  - Otherwise: go to IDLE.
- DEAD: gameOver = 1.
  - hitReq and healReq are acked and dropped, with no strobe.
  - restartReq goes to ISSUE; gameOver deasserts when SETTLE completes.
- Invulnerability counter: runs independently of the FSM state.
  - Decrements by 1 per cycle while nonzero.
  - invulnerable = (counter ≠ 0).
  - Heals are serviced normally during the window.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0.
- Request handshake:
  - A request high and selected at edge N gives strobe and ack high in cycle N→N+1.
  - The tracker updates at edge N+1.
  - SETTLE is cycle N+1→N+2.
  - IDLE resumes at edge N+2.
  - Throughput: one command per 3 cycles.
- Dropped requests (hit while invulnerable, hit/heal in DEAD, zero-room heal): ack goes high in cycle N→N+1 and the state is unchanged.
- Requester obligation: deassert the request by the edge that samples the ack. A request still high on return to IDLE is treated as a new request.
- invulnerable rises in the cycle after SETTLE of a non-fatal hit. It stays high for exactly INVULN_CYCLES cycles.
- Outputs are registered; no combinational path from input to output.
- Reset mid-operation: the FSM abandons the command immediately. No ack is produced; strobes drop asynchronously.
- Simultaneous requests: only the highest-priority request is acked; the others stay pending.

## Structure
- Package life_pkg:
  - LIFE_W = 3.
  - typedef enum for FSM states.
  - typedef enum for command kind {CMD_NONE, CMD_SET, CMD_ADD, CMD_REMOVE}.
- Sub-module invuln_timer:
  - Loadable down-counter of width $clog2(INVULN_CYCLES+1).
  - Ports: clk, resetN, load, clear, active.
- The top level holds the FSM, arbitration, clamp arithmetic and output registers.

## Test plan
Bench configuration for all scenarios: INVULN_CYCLES = 8, START_LIFE = 3, MAX_LIFE = 7, with a real lifeTracker in the loop.
1. Hit: hitReq with hitAmount = 1 from life 3 → one enableRemoveLife with amount = 1 and hitAck; life becomes 2; invulnerable high for exactly 8 cycles.
2. Hit during invulnerability: second hitReq 3 cycles after the first hit's SETTLE → hitAck with no strobe; life stays 2.
3. Heal clamp: healReq with healAmount = 7 at life 5 → enableAddLife with amount = 2; life becomes 7. A further heal of 1 → healAck only.
4. Fatal hit: hitAmount = 5 at life 3 → life 0, gameOver = 1. A following healReq → ack, no strobe. Then restartReq → enableSetLife with amount = 3, gameOver = 0, invulnerable = 0.
5. Simultaneous requests: restartReq, hitReq and healReq asserted together at life 1 → the set is served first. The hit is served 3 cycles later. The heal is served 3 cycles after the hit.
6. Reset mid-operation: resetN low during ISSUE → strobes and acks drop immediately; state is IDLE and the counter is 0 after release.
